// File: rtl/gate_stim_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gate_stim_checker_pkg
//  Description : Shared types and constants for the gates_mux stimulus /
//                response checker: FSM state encoding, vector count and a
//                vector-index-to-one-hot helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package gate_stim_checker_pkg;

    // Number of a/b input combinations exercised per run.
    localparam int NUM_VECTORS = 4;

    // Index of the final vector; reaching CHECK with this index ends the run.
    localparam logic [1:0] LAST_IDX = 2'(NUM_VECTORS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // One-hot position of a vector in the fail map.
    function automatic logic [NUM_VECTORS-1:0] vec_bit(input logic [1:0] idx);
        return NUM_VECTORS'(1) << idx;
    endfunction

endpackage : gate_stim_checker_pkg
`default_nettype wire

// File: rtl/gate_stim_checker_golden.sv
`default_nettype none
// ============================================================================
//  Module      : gate_golden
//  Description : Combinational golden reference for the universal-gate
//                outputs. Produces the expected NAND and NOR of a/b.
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_golden (
    input  logic i_a,
    input  logic i_b,
    output logic o_exp_nand,
    output logic o_exp_nor
);

    // Reference truth functions for the device under check.
    always_comb begin
        o_exp_nand = ~(i_a & i_b);
        o_exp_nor  = ~(i_a | i_b);
    end

endmodule : gate_golden
`default_nettype wire

// File: rtl/gate_stim_checker.sv
`default_nettype none
// ============================================================================
//  Module      : gate_stim_checker
//  Description : Drives a/b of gates_mux through all four combinations,
//                waits a programmable settle time, samples nand/nor and
//                compares them with golden values. Reports pass, a count of
//                failing vectors and a per-vector fail map.
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_stim_checker
    import gate_stim_checker_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   nand_in,
    input  logic                   nor_in,
    output logic                   a,
    output logic                   b,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [2:0]             err_count,
    output logic [NUM_VECTORS-1:0] fail_vec
);

    // Parameter legality is checked at elaboration so a bad build never runs.
    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("gate_stim_checker: SETTLE_CYCLES must be in 1..15");
        end
        if ((SETTLE_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
            $error("gate_stim_checker: CNT_W too narrow for SETTLE_CYCLES-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

    state_t                 state_q,    state_d;
    logic [1:0]             idx_q,      idx_d;
    logic [CNT_W-1:0]       cnt_q,      cnt_d;
    logic                   a_q,        a_d;
    logic                   b_q,        b_d;
    logic                   done_q,     done_d;
    logic                   pass_q,     pass_d;
    logic [2:0]             err_q,      err_d;
    logic [NUM_VECTORS-1:0] fail_q,     fail_d;

    logic                   w_exp_nand;
    logic                   w_exp_nor;
    logic                   w_mismatch;

    gate_golden u_golden (
        .i_a        (a_q),
        .i_b        (b_q),
        .o_exp_nand (w_exp_nand),
        .o_exp_nor  (w_exp_nor)
    );

    // Response compare; anything other than a clean match (including X in
    // simulation) falls to the else branch and is treated as a mismatch.
    always_comb begin
        w_mismatch = 1'b1;
        if ((nand_in == w_exp_nand) && (nor_in == w_exp_nor)) begin
            w_mismatch = 1'b0;
        end
    end

    // Next-state, stimulus and result update logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fail_d  = fail_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    idx_d   = 2'd0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    cnt_d   = '0;
                    err_d   = 3'd0;
                    fail_d  = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    state_d = ST_SETTLE;
                end else if (state_q == ST_DONE) begin
                    // done is exposed one edge after entering DONE, which
                    // sets the start-to-done latency of 4*(SETTLE+1)+1.
                    done_d = 1'b1;
                end
            end

            ST_SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == c_LAST_CNT) begin
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (w_mismatch) begin
                    err_d  = err_q + 3'd1;
                    fail_d = fail_q | vec_bit(idx_q);
                end
                if (idx_q == LAST_IDX) begin
                    pass_d  = (err_q == 3'd0) && !w_mismatch;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    {a_d, b_d} = idx_q + 2'd1;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    // Output mapping.
    always_comb begin
        a         = a_q;
        b         = b_q;
        busy      = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
        done      = done_q;
        pass      = pass_q;
        err_count = err_q;
        fail_vec  = fail_q;
    end

endmodule : gate_stim_checker
`default_nettype wire

// File: tb/tb_gate_stim_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gate_stim_checker
//  Description : Self-checking bench for gate_stim_checker. A faultable
//                gates_mux stand-in closes the loop; a timeline model
//                predicts every output cycle by cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_stim_checker;

    localparam int S      = 2;
    localparam int PER    = S + 1;        // edges per vector
    localparam int LAST_K = 4 * PER;      // edge count at which DONE is entered
    localparam int DONE_K = LAST_K + 1;   // edge count at which done is visible

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       nand_in;
    logic       nor_in;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] fail_vec;

    int n_checks = 0;
    int n_fail   = 0;

    // Behaviour tables of the stand-in gates_mux, bit v = response to {a,b}=v.
    logic [3:0] beh_nand;
    logic [3:0] beh_nor;
    logic [3:0] gold_nand;
    logic [3:0] gold_nor;
    int         mode;

    // Timeline model: k = edges since accepted start, negative = after reset.
    int         k     = -2;
    bit         armed = 1'b0;
    logic [3:0] exp_fail = 4'b0000;

    gate_stim_checker #(
        .SETTLE_CYCLES (S),
        .CNT_W         (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .nand_in   (nand_in),
        .nor_in    (nor_in),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_vec  (fail_vec)
    );

    always #5 clk = ~clk;

    // Stand-in for gates_mux, optionally faulted.
    always_comb begin
        nand_in = beh_nand[{a, b}];
        nor_in  = beh_nor[{a, b}];
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_mode(input int m);
        mode      = m;
        gold_nand = 4'b0111;
        gold_nor  = 4'b0001;
        case (m)
            1:       begin beh_nand = 4'b1111; beh_nor = 4'b0001; end
            2:       begin beh_nand = 4'b0000; beh_nor = 4'b0001; end
            3:       begin beh_nand = 4'b0000; beh_nor = 4'b1111; end
            default: begin beh_nand = 4'b0111; beh_nor = 4'b0001; end
        endcase
    endtask

    // Model timeline and predicted result of the run.
    always @(posedge clk) begin
        if (rst) begin
            k     <= -2;
            armed <= 1'b1;
        end else if (start && (k < 0 || k >= LAST_K)) begin
            k        <= 0;
            exp_fail <= (beh_nand ^ gold_nand) | (beh_nor ^ gold_nor);
        end else if (k >= 0 && k < DONE_K) begin
            k <= k + 1;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (armed) begin
            if (k < 0) begin
                check("rst_a",    8'(a),         8'd0);
                check("rst_b",    8'(b),         8'd0);
                check("rst_busy", 8'(busy),      8'd0);
                check("rst_done", 8'(done),      8'd0);
                check("rst_pass", 8'(pass),      8'd0);
                check("rst_err",  8'(err_count), 8'd0);
                check("rst_fail", 8'(fail_vec),  8'd0);
            end else if (k < LAST_K) begin
                check("run_busy", 8'(busy), 8'd1);
                check("run_done", 8'(done), 8'd0);
                check("run_a",    8'(a),    8'((k / PER) >> 1));
                check("run_b",    8'(b),    8'((k / PER) & 1));
            end else if (k == LAST_K) begin
                check("enter_busy", 8'(busy), 8'd0);
                check("enter_done", 8'(done), 8'd0);
            end else begin
                check("done_busy", 8'(busy),      8'd0);
                check("done_done", 8'(done),      8'd1);
                check("done_ab",   8'({a, b}),    8'd3);
                check("done_fail", 8'(fail_vec),  8'(exp_fail));
                check("done_err",  8'(err_count), 8'($countones(exp_fail)));
                check("done_pass", 8'(pass),      8'(exp_fail == 4'b0000));
            end
        end
    end

    // One start pulse, then count edges until done; poke re-pulses start.
    task automatic run(input int poke, output int lat);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("done_fall", 8'(done), 8'd0);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            start = (lat == poke);
        end
        start = 1'b0;
        check("done_timeout", 8'(done), 8'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst   = 1'b1;
        start = 1'b0;
        set_mode(0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Clean run.
        run(-1, lat);
        check("lat_clean",  8'(lat),       8'd13);
        check("lit_pass0",  8'(pass),      8'd1);
        check("lit_err0",   8'(err_count), 8'd0);
        check("lit_fail0",  8'(fail_vec),  8'b0000);

        // nand stuck at 1: only vector 3 fails (restart from DONE).
        set_mode(1);
        run(-1, lat);
        check("lat_m1",    8'(lat),       8'd13);
        check("lit_fail1", 8'(fail_vec),  8'b1000);
        check("lit_err1",  8'(err_count), 8'd1);
        check("lit_pass1", 8'(pass),      8'd0);

        // nand stuck at 0: vectors 0..2 fail.
        set_mode(2);
        run(-1, lat);
        check("lit_fail2", 8'(fail_vec),  8'b0111);
        check("lit_err2",  8'(err_count), 8'd3);
        check("lit_pass2", 8'(pass),      8'd0);

        // nand 0 and nor 1: all vectors fail, each counted once.
        set_mode(3);
        run(-1, lat);
        check("lit_fail3", 8'(fail_vec),  8'b1111);
        check("lit_err3",  8'(err_count), 8'd4);
        check("lit_pass3", 8'(pass),      8'd0);

        // Reset during vector 2 settle.
        set_mode(0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_rst_ab", 8'({a, b}), 8'd2);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("mid_rst_ab",   8'({a, b}),    8'd0);
        check("mid_rst_busy", 8'(busy),      8'd0);
        check("mid_rst_err",  8'(err_count), 8'd0);
        @(negedge clk);

        run(-1, lat);
        check("lat_after_rst",  8'(lat),  8'd13);
        check("pass_after_rst", 8'(pass), 8'd1);

        // start while busy is ignored.
        run(4, lat);
        check("lat_poke",  8'(lat),  8'd13);
        check("pass_poke", 8'(pass), 8'd1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_gate_stim_checker
`default_nettype wire
